// File: rtl/decode_stage_pkg.sv
// Shared decode constants: instruction width, opcodes, ALU encodings,
// immediate formats and the decode/execute pipeline register layout.
`ifndef INST_SIZE
`define INST_SIZE 32
`endif
`ifndef INST_SIZE_ZEROS
`define INST_SIZE_ZEROS 32'h0000_0000
`endif

package decode_stage_pkg;

    localparam int XLEN       = `INST_SIZE;
    localparam int REG_CNT    = 32;
    localparam int REG_ADDR_W = $clog2(REG_CNT);

    // RV32I major opcodes handled by this stage
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // ALU operation codes are {funct7[5], funct3}
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    // Contents of the decode/execute pipeline register
    typedef struct packed {
        logic                  valid;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       rs1_val;
        logic [XLEN-1:0]       rs2_val;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       imm;
        logic [3:0]            alu_op;
        logic [2:0]            funct3;
        logic                  src_a_pc;
        logic                  src_b_imm;
        logic                  mem_rd;
        logic                  mem_wr;
        logic                  reg_wr;
        logic                  branch;
        logic                  jump;
        logic                  illegal;
    } de_reg_t;

    // Sign-extended immediate for the given instruction format
    function automatic logic [XLEN-1:0] gen_imm(input logic [XLEN-1:0] instr,
                                                input imm_fmt_e        fmt);
        logic [XLEN-1:0] imm;
        imm = '0;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side inputs, writeback port and decode/execute outputs of the decode stage.
// Handshake: there is no valid/ready pair; the stage loads every cycle unless
// STALL holds it or FLUSH squashes it, and VALID_E qualifies the outputs.
interface decode_stage_if;
    import decode_stage_pkg::*;

    logic [XLEN-1:0]       InstrD;
    logic [XLEN-1:0]       PC_DE;
    logic                  STALL;
    logic                  FLUSH;
    logic                  WB_EN;
    logic [REG_ADDR_W-1:0] WB_ADDR;
    logic [XLEN-1:0]       WB_DATA;

    logic                  VALID_E;
    logic [XLEN-1:0]       PC_E;
    logic [XLEN-1:0]       RS1_VAL;
    logic [XLEN-1:0]       RS2_VAL;
    logic [REG_ADDR_W-1:0] RS1_E;
    logic [REG_ADDR_W-1:0] RS2_E;
    logic [REG_ADDR_W-1:0] RD_E;
    logic [XLEN-1:0]       IMM_E;
    logic [3:0]            ALU_OP_E;
    logic [2:0]            FUNCT3_E;
    logic                  SRC_A_PC_E;
    logic                  SRC_B_IMM_E;
    logic                  MEM_RD_E;
    logic                  MEM_WR_E;
    logic                  REG_WR_E;
    logic                  BRANCH_E;
    logic                  JUMP_E;
    logic                  ILLEGAL_E;

    // Upstream / environment side
    modport master (
        output InstrD, PC_DE, STALL, FLUSH, WB_EN, WB_ADDR, WB_DATA,
        input  VALID_E, PC_E, RS1_VAL, RS2_VAL, RS1_E, RS2_E, RD_E, IMM_E,
               ALU_OP_E, FUNCT3_E, SRC_A_PC_E, SRC_B_IMM_E, MEM_RD_E,
               MEM_WR_E, REG_WR_E, BRANCH_E, JUMP_E, ILLEGAL_E
    );

    // Decode stage side
    modport slave (
        input  InstrD, PC_DE, STALL, FLUSH, WB_EN, WB_ADDR, WB_DATA,
        output VALID_E, PC_E, RS1_VAL, RS2_VAL, RS1_E, RS2_E, RD_E, IMM_E,
               ALU_OP_E, FUNCT3_E, SRC_A_PC_E, SRC_B_IMM_E, MEM_RD_E,
               MEM_WR_E, REG_WR_E, BRANCH_E, JUMP_E, ILLEGAL_E
    );

endinterface

// File: rtl/decode_stage_register_file.sv
// 32-entry register file: two asynchronous read ports, one synchronous write
// port, x0 hardwired to zero, synchronous clear.
module decode_stage_register_file
    import decode_stage_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int DEPTH  = REG_CNT,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o
);

    logic [DATA_W-1:0] regs_q [DEPTH];

    // Clear on reset, otherwise commit writes to any register except x0
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // x0 reads as zero regardless of storage contents
    assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes InstrD, reads operands with writeback bypass and
// registers everything into the decode/execute pipeline register.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave de
);

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic                  funct7_b5;
    logic [REG_ADDR_W-1:0] instr_rs1;
    logic [REG_ADDR_W-1:0] instr_rs2;
    logic [REG_ADDR_W-1:0] instr_rd;

    imm_fmt_e              fmt;
    logic                  use_rs1;
    logic                  use_rs2;
    logic                  use_rd;
    de_reg_t               ctrl;
    de_reg_t               de_d;
    de_reg_t               de_q;

    logic [XLEN-1:0]       rf_rdata1;
    logic [XLEN-1:0]       rf_rdata2;
    logic                  wb_live;

    assign opcode    = de.InstrD[6:0];
    assign funct3    = de.InstrD[14:12];
    assign funct7_b5 = de.InstrD[30];
    assign instr_rs1 = de.InstrD[19:15];
    assign instr_rs2 = de.InstrD[24:20];
    assign instr_rd  = de.InstrD[11:7];

    // Instruction decode: control, immediate and architecturally-used indices
    always_comb begin
        ctrl    = '0;
        fmt     = IMM_NONE;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        if (de.InstrD != `INST_SIZE_ZEROS) begin
            ctrl.valid  = 1'b1;
            ctrl.pc     = de.PC_DE;
            ctrl.funct3 = funct3;
            case (opcode)
                OPC_OP: begin
                    ctrl.alu_op = {funct7_b5, funct3};
                    ctrl.reg_wr = 1'b1;
                    use_rs1     = 1'b1;
                    use_rs2     = 1'b1;
                    use_rd      = 1'b1;
                end
                OPC_OP_IMM: begin
                    // Only SRLI/SRAI carry funct7[5]; elsewhere it is immediate data
                    ctrl.alu_op    = {(funct3 == 3'b101) ? funct7_b5 : 1'b0, funct3};
                    ctrl.reg_wr    = 1'b1;
                    ctrl.src_b_imm = 1'b1;
                    fmt            = IMM_I;
                    use_rs1        = 1'b1;
                    use_rd         = 1'b1;
                end
                OPC_LOAD: begin
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.mem_rd    = 1'b1;
                    ctrl.reg_wr    = 1'b1;
                    ctrl.src_b_imm = 1'b1;
                    fmt            = IMM_I;
                    use_rs1        = 1'b1;
                    use_rd         = 1'b1;
                end
                OPC_STORE: begin
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.mem_wr    = 1'b1;
                    ctrl.src_b_imm = 1'b1;
                    fmt            = IMM_S;
                    use_rs1        = 1'b1;
                    use_rs2        = 1'b1;
                end
                OPC_BRANCH: begin
                    ctrl.alu_op = ALU_SUB;
                    ctrl.branch = 1'b1;
                    fmt         = IMM_B;
                    use_rs1     = 1'b1;
                    use_rs2     = 1'b1;
                end
                OPC_JAL: begin
                    ctrl.alu_op   = ALU_ADD;
                    ctrl.jump     = 1'b1;
                    ctrl.reg_wr   = 1'b1;
                    ctrl.src_a_pc = 1'b1;
                    fmt           = IMM_J;
                    use_rd        = 1'b1;
                end
                OPC_JALR: begin
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.jump      = 1'b1;
                    ctrl.reg_wr    = 1'b1;
                    ctrl.src_b_imm = 1'b1;
                    fmt            = IMM_I;
                    use_rs1        = 1'b1;
                    use_rd         = 1'b1;
                end
                OPC_LUI: begin
                    // rs1 index forced to x0 so the operand reads as zero
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.reg_wr    = 1'b1;
                    ctrl.src_b_imm = 1'b1;
                    fmt            = IMM_U;
                    use_rd         = 1'b1;
                end
                OPC_AUIPC: begin
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.reg_wr    = 1'b1;
                    ctrl.src_a_pc  = 1'b1;
                    ctrl.src_b_imm = 1'b1;
                    fmt            = IMM_U;
                    use_rd         = 1'b1;
                end
                default: begin
                    // Unsupported opcode: flagged, but no side-effecting control
                    ctrl.illegal = 1'b1;
                    ctrl.funct3  = '0;
                end
            endcase
        end
        // Unused fields are zeroed so downstream forwarding cannot match them
        ctrl.rs1 = use_rs1 ? instr_rs1 : '0;
        ctrl.rs2 = use_rs2 ? instr_rs2 : '0;
        ctrl.rd  = use_rd  ? instr_rd  : '0;
        ctrl.imm = gen_imm(de.InstrD, fmt);
    end

    decode_stage_register_file u_register_file (
        .clk      (clk),
        .rst      (rst),
        .we_i     (de.WB_EN),
        .waddr_i  (de.WB_ADDR),
        .wdata_i  (de.WB_DATA),
        .raddr1_i (ctrl.rs1),
        .raddr2_i (ctrl.rs2),
        .rdata1_o (rf_rdata1),
        .rdata2_o (rf_rdata2)
    );

    assign wb_live = de.WB_EN && (de.WB_ADDR != '0);

    // Operand read with write-through bypass from the same-cycle writeback
    always_comb begin
        de_d         = ctrl;
        de_d.rs1_val = (wb_live && (de.WB_ADDR == ctrl.rs1)) ? de.WB_DATA : rf_rdata1;
        de_d.rs2_val = (wb_live && (de.WB_ADDR == ctrl.rs2)) ? de.WB_DATA : rf_rdata2;
    end

    // Decode/execute register: reset > flush > stall > load
    always_ff @(posedge clk) begin
        if (rst) begin
            de_q <= '0;
        end else if (de.FLUSH) begin
            de_q <= '0;
        end else if (!de.STALL) begin
            de_q <= de_d;
        end
    end

    assign de.VALID_E     = de_q.valid;
    assign de.PC_E        = de_q.pc;
    assign de.RS1_VAL     = de_q.rs1_val;
    assign de.RS2_VAL     = de_q.rs2_val;
    assign de.RS1_E       = de_q.rs1;
    assign de.RS2_E       = de_q.rs2;
    assign de.RD_E        = de_q.rd;
    assign de.IMM_E       = de_q.imm;
    assign de.ALU_OP_E    = de_q.alu_op;
    assign de.FUNCT3_E    = de_q.funct3;
    assign de.SRC_A_PC_E  = de_q.src_a_pc;
    assign de.SRC_B_IMM_E = de_q.src_b_imm;
    assign de.MEM_RD_E    = de_q.mem_rd;
    assign de.MEM_WR_E    = de_q.mem_wr;
    assign de.REG_WR_E    = de_q.reg_wr;
    assign de.BRANCH_E    = de_q.branch;
    assign de.JUMP_E      = de_q.jump;
    assign de.ILLEGAL_E   = de_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with hand-computed expected values.
module tb_decode_stage;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    decode_stage_if dif ();

    decode_stage dut (
        .clk (clk),
        .rst (rst),
        .de  (dif.slave)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        dif.InstrD = instr;
        dif.PC_DE  = pc;
    endtask

    task automatic drive_wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
        dif.WB_EN   = en;
        dif.WB_ADDR = addr;
        dif.WB_DATA = data;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        dif.STALL = 1'b0;
        dif.FLUSH = 1'b0;

        // Reset with arbitrary inputs, including a writeback that must be dropped
        rst = 1'b1;
        drive(32'h00500093, 32'h0000_0100);
        drive_wb(1'b1, 5'd5, 32'h0000_1234);
        dif.STALL = 1'b1;
        dif.FLUSH = 1'b1;
        tick();
        tick();
        check("rst_valid",  {31'b0, dif.VALID_E}, 32'h0);
        check("rst_pc",     dif.PC_E, 32'h0);
        check("rst_imm",    dif.IMM_E, 32'h0);
        check("rst_rd",     {27'b0, dif.RD_E}, 32'h0);
        check("rst_regwr",  {31'b0, dif.REG_WR_E}, 32'h0);
        check("rst_srcb",   {31'b0, dif.SRC_B_IMM_E}, 32'h0);

        // addi x6,x5,0 : x5 was cleared and the reset-time write was ignored
        rst = 1'b0;
        dif.STALL = 1'b0;
        dif.FLUSH = 1'b0;
        drive_wb(1'b0, 5'd0, 32'h0);
        drive(32'h00028313, 32'h0000_0008);
        tick();
        check("x5_rs1val", dif.RS1_VAL, 32'h0);
        check("x5_rs1e",   {27'b0, dif.RS1_E}, 32'd5);
        check("x5_rde",    {27'b0, dif.RD_E}, 32'd6);

        // addi x1,x0,5 at PC 0x10
        drive(32'h00500093, 32'h0000_0010);
        tick();
        check("addi_valid", {31'b0, dif.VALID_E}, 32'h1);
        check("addi_imm",   dif.IMM_E, 32'd5);
        check("addi_rd",    {27'b0, dif.RD_E}, 32'd1);
        check("addi_regwr", {31'b0, dif.REG_WR_E}, 32'h1);
        check("addi_srcb",  {31'b0, dif.SRC_B_IMM_E}, 32'h1);
        check("addi_pc",    dif.PC_E, 32'h10);
        check("addi_alu",   {28'b0, dif.ALU_OP_E}, 32'h0);

        // add x3,x1,x2 while writeback writes x1=7: bypass
        drive(32'h002081B3, 32'h0000_0014);
        drive_wb(1'b1, 5'd1, 32'd7);
        tick();
        check("add_byp_rs1", dif.RS1_VAL, 32'd7);
        check("add_byp_rs2", dif.RS2_VAL, 32'd0);
        check("add_rs2e",    {27'b0, dif.RS2_E}, 32'd2);
        check("add_rde",     {27'b0, dif.RD_E}, 32'd3);
        check("add_srcb",    {31'b0, dif.SRC_B_IMM_E}, 32'h0);

        // Same instruction again: x1 now comes from storage
        drive_wb(1'b0, 5'd0, 32'h0);
        tick();
        check("add_reg_rs1", dif.RS1_VAL, 32'd7);

        // srai x3,x1,2 : funct7[5] reaches the ALU code
        drive(32'h4020D193, 32'h0000_0018);
        tick();
        check("srai_alu",  {28'b0, dif.ALU_OP_E}, 32'hD);
        check("srai_imm",  dif.IMM_E, 32'h0000_0402);
        check("srai_rs1",  dif.RS1_VAL, 32'd7);

        // Write to x0 is dropped and never bypassed; add x4,x0,x0
        drive(32'h00000233, 32'h0000_001C);
        drive_wb(1'b1, 5'd0, 32'hFFFF_FFFF);
        tick();
        check("x0_byp_rs1", dif.RS1_VAL, 32'h0);
        check("x0_byp_rs2", dif.RS2_VAL, 32'h0);
        drive_wb(1'b0, 5'd0, 32'h0);
        tick();
        check("x0_reg_rs1", dif.RS1_VAL, 32'h0);

        // addi x1,x0,-1024 : instr[30] set but funct3=000, so ADD
        drive(32'hC0000093, 32'h0000_0020);
        tick();
        check("addineg_alu", {28'b0, dif.ALU_OP_E}, 32'h0);
        check("addineg_imm", dif.IMM_E, 32'hFFFF_FC00);

        // lui x5,0x12345 with a live write to x8 (the rs1 field bits)
        drive(32'h123452B7, 32'h0000_0024);
        drive_wb(1'b1, 5'd8, 32'h0000_DEAD);
        tick();
        check("lui_imm",  dif.IMM_E, 32'h1234_5000);
        check("lui_rs1v", dif.RS1_VAL, 32'h0);
        check("lui_rs1e", {27'b0, dif.RS1_E}, 32'h0);
        check("lui_rs2e", {27'b0, dif.RS2_E}, 32'h0);
        check("lui_rd",   {27'b0, dif.RD_E}, 32'd5);
        drive_wb(1'b0, 5'd0, 32'h0);

        // jal x1,+8
        drive(32'h008000EF, 32'h0000_0040);
        tick();
        check("jal_imm",  dif.IMM_E, 32'd8);
        check("jal_jump", {31'b0, dif.JUMP_E}, 32'h1);
        check("jal_srca", {31'b0, dif.SRC_A_PC_E}, 32'h1);
        check("jal_rs1e", {27'b0, dif.RS1_E}, 32'h0);

        // sw x2,4(x1)
        drive(32'h0020A223, 32'h0000_0044);
        tick();
        check("sw_imm",   dif.IMM_E, 32'd4);
        check("sw_memwr", {31'b0, dif.MEM_WR_E}, 32'h1);
        check("sw_rde",   {27'b0, dif.RD_E}, 32'h0);
        check("sw_f3",    {29'b0, dif.FUNCT3_E}, 32'd2);
        check("sw_rs1v",  dif.RS1_VAL, 32'd7);

        // beq x0,x0,-4
        drive(32'hFE000EE3, 32'h0000_0048);
        tick();
        check("beq_imm",    dif.IMM_E, 32'hFFFF_FFFC);
        check("beq_branch", {31'b0, dif.BRANCH_E}, 32'h1);
        check("beq_alu",    {28'b0, dif.ALU_OP_E}, 32'h8);
        check("beq_regwr",  {31'b0, dif.REG_WR_E}, 32'h0);

        // All-ones word: unsupported opcode
        drive(32'hFFFF_FFFF, 32'h0000_004C);
        tick();
        check("ill_illegal", {31'b0, dif.ILLEGAL_E}, 32'h1);
        check("ill_valid",   {31'b0, dif.VALID_E}, 32'h1);
        check("ill_regwr",   {31'b0, dif.REG_WR_E}, 32'h0);
        check("ill_memwr",   {31'b0, dif.MEM_WR_E}, 32'h0);

        // Load addi x1,x0,5 then stall for three cycles with changing input
        drive(32'h00500093, 32'h0000_0050);
        tick();
        dif.STALL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(32'hFE000EE3 + 32'(i), 32'h0000_0100 + 32'(i * 4));
            tick();
            check("stall_valid", {31'b0, dif.VALID_E}, 32'h1);
            check("stall_imm",   dif.IMM_E, 32'd5);
            check("stall_pc",    dif.PC_E, 32'h50);
        end

        // Flush wins over stall
        dif.FLUSH = 1'b1;
        tick();
        check("flush_valid", {31'b0, dif.VALID_E}, 32'h0);
        check("flush_pc",    dif.PC_E, 32'h0);
        check("flush_regwr", {31'b0, dif.REG_WR_E}, 32'h0);

        // Bubble from fetch decodes as an invalid, non-illegal slot
        dif.FLUSH = 1'b0;
        dif.STALL = 1'b0;
        drive(32'h0000_0000, 32'h0000_0060);
        tick();
        check("bub_valid",   {31'b0, dif.VALID_E}, 32'h0);
        check("bub_illegal", {31'b0, dif.ILLEGAL_E}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipeline stage directly downstream of the fetch stage. Consumes the fetch pipeline outputs InstrD and PC_DE.
- Decodes the RV32I base subset, reads the 32x32 register file and generates a sign-extended immediate.
- Registers operands and control into the decode/execute pipeline register.
- Hosts the register-file write port driven by writeback.

Parameters:
- XLEN, 32, datapath and instruction width (equals `INST_SIZE)
- REG_CNT, 32, architectural registers; address width is log2(REG_CNT)=5

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- InstrD  in  XLEN  instruction from fetch stage
- PC_DE  in  XLEN  PC of InstrD
- STALL  in  1  hold decode/execute register contents
- FLUSH  in  1  squash: load bubble into decode/execute register (driven alongside PC_R)
- WB_EN  in  1  register-file write enable
- WB_ADDR  in  5  write address
- WB_DATA  in  XLEN  write data
- VALID_E  out  1  decode/execute register holds a real instruction
- PC_E  out  XLEN  PC of that instruction
- RS1_VAL, RS2_VAL  out  XLEN each  operand values
- RS1_E, RS2_E, RD_E  out  5 each  register indices, for forwarding
- IMM_E  out  XLEN  sign-extended immediate
- ALU_OP_E  out  4  ALU operation code
- FUNCT3_E  out  3  raw funct3 for branch/load/store width
- SRC_A_PC_E, SRC_B_IMM_E  out  1 each  ALU operand selects
- MEM_RD_E, MEM_WR_E, REG_WR_E, BRANCH_E, JUMP_E  out  1 each  control
- ILLEGAL_E  out  1  unsupported opcode was decoded

Behaviour:
- Reset (rst=1 at posedge):
  - All outputs go to 0, so VALID_E=0.
  - All 32 registers are cleared.
  - Reset takes priority over STALL, FLUSH and WB_EN.
- Latency: one cycle. Outputs reflect the InstrD/PC_DE sampled at the previous posedge.
- Priority per cycle: rst > FLUSH > STALL > normal load.
  - FLUSH: every output goes to 0, including VALID_E.
  - STALL: every output keeps its value.
  - Normal: load the decode of InstrD/PC_DE.
- Register file:
  - Written at posedge when WB_EN=1 and WB_ADDR!=0. WB_ADDR=0 writes are dropped; x0 always reads 0.
  - The write happens regardless of STALL and FLUSH (not under rst).
  - Write-through bypass: if WB_EN=1, WB_ADDR!=0 and WB_ADDR equals rs1/rs2, the value loaded into RS*_VAL is WB_DATA, not the stale register.
- Bubble: InstrD=0x00000000 (what fetch emits under reset) decodes as VALID_E=0 with all control 0 and ILLEGAL_E=0.
- Opcodes supported:
  - OP 0110011 and OP-IMM 0010011: ALU_OP={funct7[5],funct3}. funct7[5] is used for OP-IMM only on SRLI/SRAI (funct3=101); otherwise 0. REG_WR=1. SRC_B_IMM=1 for OP-IMM.
  - LOAD 0000011: I-imm, MEM_RD, REG_WR, SRC_B_IMM, ALU_OP=ADD.
  - STORE 0100011: S-imm, MEM_WR, SRC_B_IMM, ALU_OP=ADD.
  - BRANCH 1100011: B-imm, BRANCH, ALU_OP=SUB (0_000→1_000).
  - JAL 1101111: J-imm, JUMP, REG_WR, SRC_A_PC.
  - JALR 1100111: I-imm, JUMP, REG_WR, SRC_B_IMM.
  - LUI 0110111: U-imm, REG_WR, SRC_B_IMM, RS1_VAL forced to 0.
  - AUIPC 0010111: U-imm, REG_WR, SRC_A_PC, SRC_B_IMM.
- Immediates are sign-extended from instr[31]. The B and J immediates have bit0=0. The U immediate is instr[31:12]<<12.
- Any other non-zero opcode: VALID_E=1, ILLEGAL_E=1, all other control 0 (no side effects).
- RS2_E=0 for I/U/J formats. RS1_E=0 for U/J formats. RD_E=0 for S/B formats. This prevents false forwarding matches.

Decomposition:
- Shared package/constants file: opcode values, ALU_OP encodings, immediate-format enum, register-address width. Extends the existing constants (`INST_SIZE, `INST_SIZE_ZEROS).
- One natural sub-module: register_file (2 async read ports, 1 sync write port, x0 hardwired, synchronous clear).

Test Plan:
- rst=1 for 2 cycles with arbitrary inputs -> all outputs 0. Then read x5 -> RS1_VAL=0.
- InstrD=0x00500093 (addi x1,x0,5), PC_DE=0x10 -> next cycle VALID_E=1, IMM_E=5, RD_E=1, REG_WR_E=1, SRC_B_IMM_E=1, PC_E=0x10.
- Same cycle: WB_EN=1, WB_ADDR=1, WB_DATA=7, InstrD=0x002081B3 (add x3,x1,x2) -> RS1_VAL=7 (bypass). The following cycle the same instruction again gives RS1_VAL=7 from storage.
- WB_EN=1, WB_ADDR=0, WB_DATA=0xFFFFFFFF, then decode an instruction reading x0 -> RS1_VAL=0.
- InstrD=0xFE000EE3 (beq x0,x0,-4) -> IMM_E=0xFFFFFFFC, BRANCH_E=1, ALU_OP_E=SUB. InstrD=0xFFFFFFFF -> ILLEGAL_E=1, VALID_E=1, REG_WR_E=0.
- Load a valid instruction, assert STALL for 3 cycles while changing InstrD -> outputs hold. Assert STALL and FLUSH together -> VALID_E=0 next cycle.
